// File: rtl/noc_pkg.sv
// Shared flit geometry for the PE/NoC network interface.
// Flit layout, MSB first: destination, source, payload.
package noc_pkg;

  localparam int DATA_W = 36;
  localparam int ADDR_W = 4;
  localparam int PAY_LSB = 0;

  function automatic int dest_lsb(
    input int dw,
    input int aw
  );
    return dw - aw;
  endfunction

  function automatic int src_lsb(
    input int dw,
    input int aw
  );
    return dw - 2 * aw;
  endfunction

endpackage

// File: rtl/pe_noc_interface_if.sv
// PE-side and switch-side handshake bundle of the NoC interface.
// The slave modport is the interface block, master the PE/switch side.
interface pe_noc_interface_if
  import noc_pkg::*;
#(
  parameter int DataWidth = DATA_W,
  parameter int AddrWidth = ADDR_W
);

  localparam int PayW = DataWidth - 2 * AddrWidth;

  logic [PayW-1:0]      i_pe_tx_data;
  logic [AddrWidth-1:0] i_pe_tx_dest;
  logic                 i_pe_tx_valid;
  logic                 o_pe_tx_ready;
  logic [DataWidth-1:0] o_data;
  logic                 o_data_valid;
  logic                 i_data_ready;
  logic [DataWidth-1:0] i_data;
  logic                 i_data_valid;
  logic                 o_data_ready;
  logic [PayW-1:0]      o_pe_rx_data;
  logic [AddrWidth-1:0] o_pe_rx_src;
  logic                 o_pe_rx_valid;
  logic                 i_pe_rx_ready;
  logic [7:0]           o_drop_cnt;

  modport slave (
    input  i_pe_tx_data,
    input  i_pe_tx_dest,
    input  i_pe_tx_valid,
    output o_pe_tx_ready,
    output o_data,
    output o_data_valid,
    input  i_data_ready,
    input  i_data,
    input  i_data_valid,
    output o_data_ready,
    output o_pe_rx_data,
    output o_pe_rx_src,
    output o_pe_rx_valid,
    input  i_pe_rx_ready,
    output o_drop_cnt
  );

  modport master (
    output i_pe_tx_data,
    output i_pe_tx_dest,
    output i_pe_tx_valid,
    input  o_pe_tx_ready,
    input  o_data,
    input  o_data_valid,
    output i_data_ready,
    output i_data,
    output i_data_valid,
    input  o_data_ready,
    input  o_pe_rx_data,
    input  o_pe_rx_src,
    input  o_pe_rx_valid,
    output i_pe_rx_ready,
    input  o_drop_cnt
  );

endinterface

// File: rtl/noc_skid_buf.sv
// Two-entry valid/ready buffer; output fields come straight from flops.
// in_ready depends only on the occupancy register.
module noc_skid_buf #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [1:0][Width-1:0] mem_q, mem_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];

  always_comb begin
    push  = in_valid && in_ready;
    pop   = out_valid && out_ready;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pe_noc_interface.sv
// Network interface between one PE and its switch port.
// Packs/unpacks flits, filters by address and counts discarded flits.
module pe_noc_interface
  import noc_pkg::*;
#(
  parameter int DataWidth = DATA_W,
  parameter int AddrWidth = ADDR_W,
  parameter int MyAddr    = 0
) (
  input logic              i_clk,
  input logic              i_resetn,
  pe_noc_interface_if.slave bus
);

  localparam int PayW   = DataWidth - 2 * AddrWidth;
  localparam int RxW    = DataWidth - AddrWidth;
  localparam int DstLsb = dest_lsb(DataWidth, AddrWidth);
  localparam int SrcLsb = src_lsb(DataWidth, AddrWidth);
  localparam logic [AddrWidth-1:0] MyA = AddrWidth'(MyAddr);

  // Async assert, release on the first edge; also gates both readies.
  logic rst_ok_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      rst_ok_q <= 1'b0;
    end else begin
      rst_ok_q <= 1'b1;
    end
  end

  logic                 tx_buf_rdy;
  logic                 tx_rdy;
  logic                 tx_fire;
  logic                 tx_self;
  logic                 tx_push;
  logic [DataWidth-1:0] tx_flit;

  assign tx_rdy  = rst_ok_q && tx_buf_rdy;
  assign tx_fire = bus.i_pe_tx_valid && tx_rdy;
  assign tx_self = tx_fire && (bus.i_pe_tx_dest == MyA);
  assign tx_push = tx_fire && !tx_self;
  assign tx_flit = {bus.i_pe_tx_dest, MyA, bus.i_pe_tx_data};
  assign bus.o_pe_tx_ready = tx_rdy;

  noc_skid_buf #(
    .Width (DataWidth)
  ) u_tx_buf (
    .clk       (i_clk),
    .rst_n     (rst_ok_q),
    .in_data   (tx_flit),
    .in_valid  (tx_push),
    .in_ready  (tx_buf_rdy),
    .out_data  (bus.o_data),
    .out_valid (bus.o_data_valid),
    .out_ready (bus.i_data_ready)
  );

  logic           rx_buf_rdy;
  logic           rx_rdy;
  logic           rx_fire;
  logic           rx_hit;
  logic           rx_push;
  logic           rx_miss;
  logic [RxW-1:0] rx_word;

  assign rx_rdy  = rst_ok_q && rx_buf_rdy;
  assign rx_fire = bus.i_data_valid && rx_rdy;
  assign rx_hit  = (bus.i_data[DstLsb +: AddrWidth] == MyA);
  assign rx_push = rx_fire && rx_hit;
  assign rx_miss = rx_fire && !rx_hit;
  assign bus.o_data_ready = rx_rdy;

  // Destination is implied once stored, so only src+payload are kept.
  noc_skid_buf #(
    .Width (RxW)
  ) u_rx_buf (
    .clk       (i_clk),
    .rst_n     (rst_ok_q),
    .in_data   (bus.i_data[RxW-1:0]),
    .in_valid  (rx_push),
    .in_ready  (rx_buf_rdy),
    .out_data  (rx_word),
    .out_valid (bus.o_pe_rx_valid),
    .out_ready (bus.i_pe_rx_ready)
  );

  assign bus.o_pe_rx_data = rx_word[PAY_LSB +: PayW];
  assign bus.o_pe_rx_src  = rx_word[SrcLsb +: AddrWidth];

  logic [7:0] drop_q, drop_d;
  logic [8:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'(tx_self) + 9'(rx_miss);
    drop_d   = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
  end

  always_ff @(posedge i_clk or negedge rst_ok_q) begin
    if (!rst_ok_q) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.o_drop_cnt = drop_q;

endmodule
